// File: rtl/prng_stream_checker.sv
// rtl/prng_stream_checker.sv - LFSR byte-stream checker with lock/loss tracking.
// Optional error counter and clear_i are enabled by defining PRNG_CHK_ERRCNT_EN.
module prng_stream_checker #(
  parameter int ERR_W       = 8,
  parameter int LOCK_COUNT  = 8,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seed_i,
  input  logic             seed_load_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_LOST    = 3'd4
  } state_e;

  localparam logic [7:0] LOCK_B = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_B = 8'(LOSS_THRESH);

  state_e      state_q, state_d;
  logic [15:0] s_q, s_d;
  logic [7:0]  match_q, match_d;
  logic [7:0]  miss_q, miss_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        locked_q, locked_d;
  logic        cnt_inc;

  function automatic logic [7:0] exp_byte(input logic [15:0] s);
    return {s[14:8], s[15]} ^ {s[0], s[7:1]};
  endfunction

  logic [7:0]  exp_w;
  logic [15:0] s_adv;
  logic        accept;
  logic        hit;
  logic [7:0]  match_inc;
  logic [7:0]  miss_inc;

  assign exp_w     = exp_byte(s_q);
  assign s_adv     = {s_q[14:0], s_q[15] ^ s_q[14] ^ s_q[12] ^ s_q[3]};
  assign accept    = valid_i & ready_q;
  assign hit       = (data_i == exp_w);
  assign match_inc = match_q + 8'd1;
  assign miss_inc  = miss_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_d    = 1'b0;
    cnt_inc  = 1'b0;
    // A seed strobe overrides any byte accepted in the same cycle.
    if (seed_load_i) begin
      state_d = ST_SEED;
      s_d     = {seed_i, seed_i};
      match_d = 8'd0;
      miss_d  = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SEED: state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (accept) begin
            s_d = s_adv;
            if (hit) begin
              match_d = match_inc;
              if (match_inc >= LOCK_B) begin
                state_d = ST_LOCKED;
              end
            end else begin
              match_d = 8'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            s_d = s_adv;
            if (hit) begin
              miss_d = 8'd0;
            end else begin
              err_d   = 1'b1;
              cnt_inc = 1'b1;
              miss_d  = miss_inc;
              if (miss_inc >= LOSS_B) begin
                state_d = ST_LOST;
              end
            end
          end
        end
        ST_LOST: ;
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d  = (state_d != ST_SEED);
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= 16'h0000;
      match_q  <= 8'd0;
      miss_q   <= 8'd0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      locked_q <= locked_d;
    end
  end

`ifdef PRNG_CHK_ERRCNT_EN
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [ERR_W-1:0] cnt_q, cnt_d;

  // Clear takes priority over an error counted in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != ERR_MAX)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt_o = cnt_q;
`else
  logic unused_sigs;
  assign unused_sigs = clear_i | cnt_inc;
  assign err_cnt_o   = '0;
`endif

  assign ready_o  = ready_q;
  assign locked_o = locked_q;
  assign err_o    = err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_prng_stream_checker.sv
// tb/tb_prng_stream_checker.sv - directed self-checking bench for prng_stream_checker.
module tb_prng_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] seed, data;
  logic       seed_load, valid, clear;
  logic       ready, locked, err;
  logic [7:0] cnt;
  logic [2:0] state;

  logic [7:0] seed2, data2;
  logic       seed_load2, valid2, clear2;
  logic       ready2, locked2, err2;
  logic [1:0] cnt2;
  logic [2:0] state2;

  int checks = 0;
  int failures = 0;

`ifdef PRNG_CHK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  prng_stream_checker #(.ERR_W(8), .LOCK_COUNT(8), .LOSS_THRESH(4)) dut (
    .clk(clk), .rst(rst), .seed_i(seed), .seed_load_i(seed_load),
    .data_i(data), .valid_i(valid), .ready_o(ready), .clear_i(clear),
    .locked_o(locked), .err_o(err), .err_cnt_o(cnt), .state_o(state)
  );

  prng_stream_checker #(.ERR_W(2), .LOCK_COUNT(8), .LOSS_THRESH(8)) dut_sat (
    .clk(clk), .rst(rst), .seed_i(seed2), .seed_load_i(seed_load2),
    .data_i(data2), .valid_i(valid2), .ready_o(ready2), .clear_i(clear2),
    .locked_o(locked2), .err_o(err2), .err_cnt_o(cnt2), .state_o(state2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [15:0] s);
    return {s[14:8], s[15]} ^ {s[0], s[7:1]};
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  function automatic logic [31:0] cexp(input int v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ms, ms2;

  // Eight correct bytes from seed 0xA5; the first two are hand-derived.
  task automatic lock_seq(input string tag);
    for (int i = 0; i < 8; i++) begin
      data  = (i == 0) ? 8'h99 : (i == 1) ? 8'h33 : exp_byte(ms);
      valid = 1'b1;
      step();
      ms = adv(ms);
      check(tag, 32'(locked), 32'(i == 7));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},  32'(state),  0);
    check({tag, "_ready"},  32'(ready),  1);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err"},    32'(err),    0);
    check({tag, "_cnt"},    32'(cnt),    0);
  endtask

  initial begin
    rst = 1'b1;
    seed = 8'h00; data = 8'h00; seed_load = 1'b0; valid = 1'b0; clear = 1'b0;
    seed2 = 8'h00; data2 = 8'h00; seed_load2 = 1'b0; valid2 = 1'b0; clear2 = 1'b0;
    ms = 16'h0000; ms2 = 16'h0000;
    step(); step();
    check_reset("rst");
    rst = 1'b0;

    valid = 1'b1; data = 8'h99;
    step();
    check("idle_state", 32'(state), 0);
    check("idle_err", 32'(err), 0);

    valid = 1'b0; seed = 8'hA5; seed_load = 1'b1;
    step();
    check("seed_state", 32'(state), 1);
    check("seed_ready", 32'(ready), 0);
    seed_load = 1'b0;
    step();
    check("acq_state", 32'(state), 2);
    check("acq_ready", 32'(ready), 1);

    ms = 16'hA5A5;
    lock_seq("lock1");
    check("lock1_state", 32'(state), 3);
    check("lock1_err", 32'(err), 0);
    check("lock1_cnt", 32'(cnt), 0);

    data = exp_byte(ms); step(); ms = adv(ms);
    check("b9_err", 32'(err), 0);
    data = exp_byte(ms) ^ 8'h01; step(); ms = adv(ms);
    check("b10_err", 32'(err), 1);
    check("b10_cnt", 32'(cnt), cexp(1));
    check("b10_state", 32'(state), 3);
    for (int i = 0; i < 3; i++) begin
      data = exp_byte(ms); step(); ms = adv(ms);
      check("post_err", 32'(err), 0);
    end
    check("post_locked", 32'(locked), 1);
    check("post_cnt", 32'(cnt), cexp(1));

    valid = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    check("clear_cnt", 32'(cnt), 0);

    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data = exp_byte(ms) ^ 8'h80; step(); ms = adv(ms);
      check("miss_err", 32'(err), 1);
      check("miss_state", 32'(state), (i == 3) ? 4 : 3);
    end
    check("lost_locked", 32'(locked), 0);
    check("lost_cnt", 32'(cnt), cexp(4));

    for (int i = 0; i < 3; i++) begin
      data = exp_byte(ms) ^ 8'hFF; step();
      check("lost_ign_err", 32'(err), 0);
      check("lost_ign_state", 32'(state), 4);
      check("lost_ign_ready", 32'(ready), 1);
    end
    check("lost_ign_cnt", 32'(cnt), cexp(4));

    valid = 1'b0; seed_load = 1'b1; seed = 8'hA5; step();
    check("reseed_state", 32'(state), 1);
    seed_load = 1'b0; step();
    check("reseed_acq", 32'(state), 2);
    check("reseed_cnt", 32'(cnt), cexp(4));
    ms = 16'hA5A5;
    lock_seq("lock2");

    // Seed strobe together with a wrong byte while LOCKED: byte must be dropped.
    valid = 1'b1; data = ~exp_byte(ms); seed_load = 1'b1; seed = 8'hA5;
    step();
    check("same_err", 32'(err), 0);
    check("same_state", 32'(state), 1);
    check("same_ready", 32'(ready), 0);
    check("same_locked", 32'(locked), 0);
    check("same_cnt", 32'(cnt), cexp(4));
    seed_load = 1'b0; data = 8'h00;
    step();
    check("same_acq", 32'(state), 2);
    check("same_ready1", 32'(ready), 1);
    ms = 16'hA5A5;
    lock_seq("lock3");

    valid = 1'b0; seed_load = 1'b1; step(); seed_load = 1'b0; step();
    ms = 16'hA5A5;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = exp_byte(ms); step(); ms = adv(ms);
    end
    check("mid_acq", 32'(state), 2);
    #2;
    rst = 1'b1;
    #1;
    check_reset("arst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = exp_byte(ms); step(); ms = adv(ms);
      check("arst_ign_state", 32'(state), 0);
      check("arst_ign_err", 32'(err), 0);
    end
    valid = 1'b0;

    seed2 = 8'hA5; seed_load2 = 1'b1; step(); seed_load2 = 1'b0; step();
    ms2 = 16'hA5A5;
    valid2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data2 = exp_byte(ms2); step(); ms2 = adv(ms2);
    end
    check("sat_locked", 32'(locked2), 1);
    for (int i = 0; i < 5; i++) begin
      data2 = exp_byte(ms2) ^ 8'h01;
      clear2 = (i == 4);
      step(); ms2 = adv(ms2);
      check("sat_err", 32'(err2), 1);
      check("sat_cnt", 32'(cnt2), cexp((i == 4) ? 0 : (i >= 2) ? 3 : i + 1));
    end
    clear2 = 1'b0; valid2 = 1'b0;
    step();
    check("sat_state", 32'(state2), 3);
    check("sat_cnt_after", 32'(cnt2), 0);
    check("sat_err_after", 32'(err2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
